// File: rtl/ahb_slave_pipe_if.sv
// AHB slave-side bundle between the master model and the bridge front end.
// The slave modport is the bridge's view; the master modport drives the AHB inputs.
interface ahb_slave_pipe_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] Haddr;
    logic [DW-1:0] Hwdata;
    logic          Hwrite;
    logic [1:0]    Htrans;
    logic          Hreadyin;
    logic          apb_busy;
    logic          Hreadyout;
    logic [1:0]    Hresp;
    logic          valid;
    logic [2:0]    tempselx;
    logic [AW-1:0] Haddr1;
    logic [AW-1:0] Haddr2;
    logic [DW-1:0] Hwdata1;
    logic [DW-1:0] Hwdata2;
    logic          Hwrite_reg;
    logic          Hwrite_reg1;

    modport slave (
        input  Haddr, Hwdata, Hwrite, Htrans, Hreadyin, apb_busy,
        output Hreadyout, Hresp, valid, tempselx,
        output Haddr1, Haddr2, Hwdata1, Hwdata2, Hwrite_reg, Hwrite_reg1
    );

    modport master (
        output Haddr, Hwdata, Hwrite, Htrans, Hreadyin, apb_busy,
        input  Hreadyout, Hresp, valid, tempselx,
        input  Haddr1, Haddr2, Hwdata1, Hwdata2, Hwrite_reg, Hwrite_reg1
    );
endinterface

// File: rtl/ahb_slave_pipe.sv
// AHB front end: decodes the address into one of three APB selects and pipelines the transfer.
// Latency: valid/tempselx/Haddr1 one cycle after the address phase; Haddr2/Hwdata1 one cycle later.
// Backpressure: Hreadyout follows ~apb_busy in OKAY; an unmapped access forces a two-cycle ERROR response.
module ahb_slave_pipe #(
    parameter int            AW    = 32,
    parameter int            DW    = 32,
    parameter logic [AW-1:0] BASE0 = 32'h8000_0000,
    parameter logic [AW-1:0] BASE1 = 32'h8400_0000,
    parameter logic [AW-1:0] BASE2 = 32'h8800_0000,
    parameter logic [AW-1:0] RSIZE = 32'h0400_0000
) (
    input  logic               Hclk,
    input  logic               Hresetn,
    ahb_slave_pipe_if.slave    bus
);
    localparam logic [AW-1:0] END0 = BASE0 + RSIZE;
    localparam logic [AW-1:0] END1 = BASE1 + RSIZE;
    localparam logic [AW-1:0] END2 = BASE2 + RSIZE;

    typedef enum logic [1:0] {OKAY, ERR1, ERR2} state_t;

    state_t        state;
    logic [1:0]    hresp_q;
    logic          valid_q;
    logic [2:0]    selx_q;
    logic [AW-1:0] addr1_q, addr2_q;
    logic [DW-1:0] wdata1_q, wdata2_q;
    logic          write1_q, write2_q;

    logic [2:0]    sel;
    logic          act;
    logic          vld_nxt;

    always_comb begin
        sel = 3'b000;
        if (bus.Haddr >= BASE0 && bus.Haddr < END0)
            sel = 3'b001;
        else if (bus.Haddr >= BASE1 && bus.Haddr < END1)
            sel = 3'b010;
        else if (bus.Haddr >= BASE2 && bus.Haddr < END2)
            sel = 3'b100;
    end

    assign act     = bus.Hreadyin & bus.Htrans[1];
    assign vld_nxt = act & (sel != 3'b000) & (state == OKAY);

    always_ff @(posedge Hclk or posedge Hresetn) begin
        if (Hresetn) begin
            state    <= OKAY;
            hresp_q  <= 2'b00;
            valid_q  <= 1'b0;
            selx_q   <= 3'b000;
            addr1_q  <= '0;
            addr2_q  <= '0;
            wdata1_q <= '0;
            wdata2_q <= '0;
            write1_q <= 1'b0;
            write2_q <= 1'b0;
        end else begin
            if (bus.Hreadyin) begin
                addr1_q  <= bus.Haddr;
                addr2_q  <= addr1_q;
                write1_q <= bus.Hwrite;
                write2_q <= write1_q;
                wdata1_q <= bus.Hwdata;
                wdata2_q <= wdata1_q;
            end
            valid_q <= vld_nxt;
            selx_q  <= vld_nxt ? sel : 3'b000;

            // ERR1/ERR2 ignore new requests; the master is expected to drive IDLE meanwhile
            case (state)
                OKAY: begin
                    if (act && sel == 3'b000) begin
                        state   <= ERR1;
                        hresp_q <= 2'b01;
                    end
                end
                ERR1: state <= ERR2;
                ERR2: begin
                    state   <= OKAY;
                    hresp_q <= 2'b00;
                end
                default: begin
                    state   <= OKAY;
                    hresp_q <= 2'b00;
                end
            endcase
        end
    end

    // Hreadyout depends only on state and apb_busy, never on the incoming address
    assign bus.Hreadyout   = (state == ERR2) | ((state == OKAY) & ~bus.apb_busy);
    assign bus.Hresp       = hresp_q;
    assign bus.valid       = valid_q;
    assign bus.tempselx    = selx_q;
    assign bus.Haddr1      = addr1_q;
    assign bus.Haddr2      = addr2_q;
    assign bus.Hwdata1     = wdata1_q;
    assign bus.Hwdata2     = wdata2_q;
    assign bus.Hwrite_reg  = write1_q;
    assign bus.Hwrite_reg1 = write2_q;
endmodule

// File: tb/tb_ahb_slave_pipe.sv
// Directed plus randomized bench for ahb_slave_pipe against a transaction-level reference model.
module tb_ahb_slave_pipe;
    localparam logic [31:0] RBASE = 32'h8000_0000;
    localparam logic [31:0] RSZ   = 32'h0400_0000;

    logic Hclk = 1'b0;
    logic Hresetn = 1'b1;
    always #5 Hclk = ~Hclk;

    ahb_slave_pipe_if #(.AW(32), .DW(32)) bus ();

    ahb_slave_pipe dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    // reference state
    int          err_cnt;   // 0 = normal, 2 = first error cycle, 1 = second error cycle
    logic        m_valid;
    logic [2:0]  m_sel;
    logic [31:0] m_a1, m_a2, m_d1, m_d2;
    logic        m_w1, m_w2;

    function automatic logic [2:0] ref_sel(logic [31:0] a);
        logic [31:0] off;
        logic [2:0]  one;
        int          idx;
        one = 3'b001;
        if (a < RBASE) return 3'b000;
        off = a - RBASE;
        idx = int'(off / RSZ);
        if (idx < 3) return one << idx;
        return 3'b000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        err_cnt = 0; m_valid = 0; m_sel = 0;
        m_a1 = 0; m_a2 = 0; m_d1 = 0; m_d2 = 0; m_w1 = 0; m_w2 = 0;
    endtask

    task automatic check_all(input string tag);
        logic exp_rdy;
        exp_rdy = (err_cnt == 2) ? 1'b0 : (err_cnt == 1) ? 1'b1 : ~bus.apb_busy;
        chk({tag, ".valid"},    32'(bus.valid),       32'(m_valid));
        chk({tag, ".selx"},     32'(bus.tempselx),    32'(m_sel));
        chk({tag, ".haddr1"},   bus.Haddr1,           m_a1);
        chk({tag, ".haddr2"},   bus.Haddr2,           m_a2);
        chk({tag, ".hwdata1"},  bus.Hwdata1,          m_d1);
        chk({tag, ".hwdata2"},  bus.Hwdata2,          m_d2);
        chk({tag, ".hwrite1"},  32'(bus.Hwrite_reg),  32'(m_w1));
        chk({tag, ".hwrite2"},  32'(bus.Hwrite_reg1), 32'(m_w2));
        chk({tag, ".hresp"},    32'(bus.Hresp),       (err_cnt != 0) ? 32'd1 : 32'd0);
        chk({tag, ".hreadyout"}, 32'(bus.Hreadyout),  32'(exp_rdy));
    endtask

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic tick(input string tag);
        logic [31:0] a, wd;
        logic        w, ri, act;
        logic [1:0]  tr;
        logic [2:0]  s;
        a = bus.Haddr; wd = bus.Hwdata; w = bus.Hwrite; tr = bus.Htrans; ri = bus.Hreadyin;
        @(posedge Hclk);
        #1;
        act = ri & tr[1];
        s = ref_sel(a);
        m_valid = act && (s != 0) && (err_cnt == 0);
        m_sel   = m_valid ? s : 3'b000;
        if (ri) begin
            m_a2 = m_a1; m_a1 = a;
            m_w2 = m_w1; m_w1 = w;
            m_d2 = m_d1; m_d1 = wd;
        end
        if (err_cnt > 0) err_cnt--;
        else if (act && s == 0) err_cnt = 2;
        check_all(tag);
    endtask

    task automatic drive(input logic [31:0] a, input logic w, input logic [1:0] tr,
                         input logic [31:0] wd, input logic ri, input logic busy);
        bus.Haddr = a; bus.Hwrite = w; bus.Htrans = tr;
        bus.Hwdata = wd; bus.Hreadyin = ri; bus.apb_busy = busy;
    endtask

    task automatic release_reset();
        @(posedge Hclk);
        #1;
        Hresetn = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] a;
        int          cat;
        model_reset();
        drive(32'h0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0);
        #1;
        check_all("por");
        release_reset();
        tick("idle0");
        tick("idle1");

        // single write
        drive(32'h8000_0010, 1'b1, 2'b10, 32'h0, 1'b1, 1'b0);
        tick("wr_a");
        chk("wr_valid", 32'(bus.valid), 32'd1);
        chk("wr_selx", 32'(bus.tempselx), 32'd1);
        chk("wr_haddr1", bus.Haddr1, 32'h8000_0010);
        drive(32'h0, 1'b0, 2'b00, 32'hDEAD_BEEF, 1'b1, 1'b0);
        tick("wr_d");
        chk("wr_hwdata1", bus.Hwdata1, 32'hDEAD_BEEF);
        chk("wr_haddr2", bus.Haddr2, 32'h8000_0010);

        // burst read in region 1
        drive(32'h8400_0000, 1'b0, 2'b10, 32'h0, 1'b1, 1'b0);
        tick("br0");
        drive(32'h8400_0004, 1'b0, 2'b11, 32'h0, 1'b1, 1'b0);
        tick("br1");
        drive(32'h8400_0008, 1'b0, 2'b11, 32'h0, 1'b1, 1'b0);
        tick("br2");
        chk("br_selx", 32'(bus.tempselx), 32'd2);
        chk("br_haddr2", bus.Haddr2, 32'h8400_0004);
        drive(32'h0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0);
        tick("br3");

        // unmapped access while APB is busy: error wins
        drive(32'h9000_0000, 1'b0, 2'b10, 32'h0, 1'b1, 1'b1);
        tick("un0");
        chk("un_rdy0", 32'(bus.Hreadyout), 32'd0);
        chk("un_resp0", 32'(bus.Hresp), 32'd1);
        drive(32'h8000_0000, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0);
        tick("un1");
        chk("un_rdy1", 32'(bus.Hreadyout), 32'd1);
        tick("un2");
        chk("un_resp2", 32'(bus.Hresp), 32'd0);

        // backpressure with Hreadyout looped back to Hreadyin
        drive(32'h8800_0020, 1'b1, 2'b10, 32'h0, 1'b1, 1'b0);
        tick("bp0");
        drive(32'h8800_0040, 1'b1, 2'b10, 32'h1234_5678, 1'b0, 1'b1);
        #1;
        chk("bp_rdy_busy", 32'(bus.Hreadyout), 32'd0);
        tick("bp1");
        chk("bp_hold", bus.Haddr1, 32'h8800_0020);
        bus.apb_busy = 1'b0;
        #1;
        chk("bp_rdy_free", 32'(bus.Hreadyout), 32'd1);
        drive(32'h8800_0040, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0);
        tick("bp2");

        // IDLE and BUSY to mapped and unmapped addresses
        drive(32'h8000_0100, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0);
        tick("idle_m");
        drive(32'hF000_0000, 1'b0, 2'b01, 32'h0, 1'b1, 1'b0);
        tick("busy_u");

        // region boundaries
        drive(32'h7FFF_FFFF, 1'b0, 2'b10, 32'h0, 1'b1, 1'b0);
        tick("bd_lo");
        drive(32'h0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0);
        tick("bd_lo_e1");
        tick("bd_lo_e2");
        drive(32'h8BFF_FFFC, 1'b1, 2'b10, 32'h0, 1'b1, 1'b0);
        tick("bd_top");
        drive(32'h8C00_0000, 1'b1, 2'b10, 32'h0, 1'b1, 1'b0);
        tick("bd_end");
        drive(32'h0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0);
        tick("bd_end_e1");
        tick("bd_end_e2");

        // reset mid-transfer
        drive(32'h8000_0040, 1'b1, 2'b10, 32'h5555_AAAA, 1'b1, 1'b0);
        tick("rs_pre");
        Hresetn = 1'b1;
        #1;
        model_reset();
        check_all("rs_mid");
        release_reset();
        drive(32'h0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0);
        tick("rs_idle");

        // reset during an error response
        drive(32'hA000_0000, 1'b0, 2'b10, 32'h0, 1'b1, 1'b0);
        tick("rse0");
        Hresetn = 1'b1;
        #1;
        model_reset();
        check_all("rs_err");
        release_reset();
        drive(32'h0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0);
        tick("rse_idle");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cat = int'($urandom_range(0, 6));
            case (cat)
                0: a = RBASE + $urandom_range(0, 32'h03FF_FFFF);
                1: a = RBASE + RSZ + $urandom_range(0, 32'h03FF_FFFF);
                2: a = RBASE + 2 * RSZ + $urandom_range(0, 32'h03FF_FFFF);
                3: a = RBASE - 32'd1 - $urandom_range(0, 3);
                4: a = RBASE + 3 * RSZ + $urandom_range(0, 3);
                default: a = $urandom;
            endcase
            drive(a, 1'($urandom), 2'($urandom), $urandom,
                  ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0));
            tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
